text_overlay: RTL and testbench
===============================

Name: text_overlay

Overview:
- Parametrised text-bitmap overlay for the 640x480 VGA path; successor to the fixed single-message text box.
- Compares the pixel counters against a configurable box, fetches bitmap rows from an external synchronous ROM, and emits a registered text-pixel flag plus colour to the pixel mixer.
- Adds message select, integer pixel scaling, frame-synchronous blink and a fixed, documented pipeline latency.

Parameters:
- X0, 10, left edge of box, in pixels.
- Y0, 150, top edge of box, in pixels.
- WIDTH, 108, bitmap columns (bits per ROM word).
- HEIGHT, 26, bitmap rows per message.
- NUM_MSG, 4, messages stored back to back in ROM.
- SCALE_LOG2, 0, box magnification is 2^SCALE_LOG2 in both axes.
- BLINK_FRAMES, 30, frames per blink half-period.
- ADDR_W, 7, ROM address width; must satisfy 2^ADDR_W >= NUM_MSG*HEIGHT.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- HCount  in  10  current pixel column
- VCount  in  10  current pixel row
- enable  in  1  overlay on/off; sampled at frame start
- msg_sel  in  2  message index; sampled at frame start
- blink_en  in  1  blink mode; sampled at frame start
- colour  in  3  RGB of text pixels; sampled at frame start
- rom_addr  out  ADDR_W  registered ROM row address
- rom_data  in  WIDTH  ROM word; valid 1 cycle after rom_addr
- texton  out  1  text pixel active
- rgbtext  out  3  pixel colour

Behaviour:
- Reset (async): texton=0, rgbtext=0, rom_addr=0, pipeline valid bits=0, frame counter=0, blink phase=visible, latched config=0 (overlay disabled).
- Frame start: HCount==0 && VCount==0 sampled. On that cycle, latch enable, msg_sel (clamped to NUM_MSG-1 if larger), blink_en and colour. No mid-frame tearing.
- Box: in_box = X0 <= H < X0+(WIDTH<<S) and Y0 <= V < Y0+(HEIGHT<<S), where S=SCALE_LOG2. Use 11-bit comparisons so the right/bottom edges cannot wrap.
- row = (V-Y0)>>S; col = (H-X0)>>S.
- Stage 1 (edge after sample): rom_addr <= msg*HEIGHT + row if in_box, else it holds its value. Register col and in_box.
- Stage 2: rom_data is valid. Register bit = rom_data[col]; col 0 maps to LSB. Propagate in_box.
- Stage 3: texton <= in_box_d2 & bit & enable_l & visible. rgbtext <= colour_l when texton, else 3'b000.
- Latency is exactly 3 clocks from HCount/VCount to texton/rgbtext. The mixer delays its own path by 3.
- Blink counter:
  - Increments once per frame start. At BLINK_FRAMES-1 it wraps to 0 and visible toggles.
  - With blink_en_l=0, visible is forced to 1 and the counter keeps running.
- Out of box: texton=0 regardless of ROM content.
- Reset mid-frame: outputs go to 0 immediately. Overlay stays dark until the next frame start latches the config.

Optional Feature:
- TEXT_BG_EN.
- Defined: adds input bgcolour[2:0], latched at frame start. Inside the box, texton=1 for every pixel (subject to enable and visible). rgbtext = colour_l on set bits, bgcolour_l on clear bits.
- Undefined: no bgcolour port; behaviour as above.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE=640 and V_ACTIVE=480
  - 3-bit RGB colour constants: BLACK, BLUE=3'b001, WHITE
  - the TEXT_LATENCY=3 constant
- One natural sub-module, blink_timer: frame-start pulse in, visible out, parameter BLINK_FRAMES.
- The ROM stays external so that different message sets can be bound.

Test Plan:
- Defaults, msg_sel=0, enable=1, ROM row0=all ones: (H,V)=(10,150) -> texton=1, rgbtext=colour 3 clocks later. (9,150), (118,150) and (10,176) -> texton=0.
- msg_sel=2 latched: V=155 inside box -> rom_addr=2*26+5=57 one clock after sample.
- SCALE_LOG2=1: pixels (10,150) and (11,151) both map to col 0 / row 0. The box ends at H=226 and V=202.
- blink_en=1, BLINK_FRAMES=2: texton pattern by frame index 0..5 is on, on, off, off, on, on.
- msg_sel changed mid-frame from 0 to 1: rom_addr keeps the message-0 base until the next frame start.
- Assert reset during active text: texton=0 in the same cycle, and stays 0 until after the next frame start with enable=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and colour type for the 640x480 pixel path.
// Used by text_overlay and its interface.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int TEXT_LATENCY = 3;

  typedef logic [2:0] rgb_t;

  localparam rgb_t BLACK = 3'b000;
  localparam rgb_t BLUE  = 3'b001;
  localparam rgb_t WHITE = 3'b111;

endpackage

// File: rtl/text_overlay_if.sv
// Pixel, configuration, ROM and output signals of the text overlay.
// Optional TEXT_BG_EN adds the bgcolour input.
interface text_overlay_if #(
  parameter int WIDTH  = 108,
  parameter int ADDR_W = 7
);
  import vga_pkg::*;

  logic [9:0]        HCount;
  logic [9:0]        VCount;
  logic              enable;
  logic [1:0]        msg_sel;
  logic              blink_en;
  rgb_t              colour;
`ifdef TEXT_BG_EN
  rgb_t              bgcolour;
`endif
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              texton;
  rgb_t              rgbtext;

`ifdef TEXT_BG_EN
  modport master (
    input  HCount, VCount, enable, msg_sel, blink_en, colour, bgcolour, rom_data,
    output rom_addr, texton, rgbtext
  );
  modport slave (
    output HCount, VCount, enable, msg_sel, blink_en, colour, bgcolour, rom_data,
    input  rom_addr, texton, rgbtext
  );
`else
  modport master (
    input  HCount, VCount, enable, msg_sel, blink_en, colour, rom_data,
    output rom_addr, texton, rgbtext
  );
  modport slave (
    output HCount, VCount, enable, msg_sel, blink_en, colour, rom_data,
    input  rom_addr, texton, rgbtext
  );
`endif

endinterface

// File: rtl/text_overlay_blink_timer.sv
// Frame-synchronous blink phase generator: toggles the phase every
// BLINK_FRAMES frame starts; visible is forced high while blink is off.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic blink_en,
  output logic visible
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] count_reg;
  logic             phase_reg;

  // The counter runs even with blink disabled so the phase stays frame-locked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      phase_reg <= 1'b1;
    end else if (frame_start) begin
      if (count_reg == LAST) begin
        count_reg <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign visible = phase_reg | ~blink_en;

endmodule

// File: rtl/text_overlay.sv
// Text-bitmap overlay: box compare, external sync ROM fetch, 3-clock
// pixel pipeline. Optional macro TEXT_BG_EN fills clear bits with bgcolour.
module text_overlay
  import vga_pkg::*;
#(
  parameter int X0           = 10,
  parameter int Y0           = 150,
  parameter int WIDTH        = 108,
  parameter int HEIGHT       = 26,
  parameter int NUM_MSG      = 4,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int ADDR_W       = 7
) (
  input logic             clk,
  input logic             reset,
  text_overlay_if.master  bus
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (WIDTH << SCALE_LOG2));
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + (HEIGHT << SCALE_LOG2));
  localparam logic [1:0]  MSG_MAX = 2'(NUM_MSG - 1);

  logic              frame_start;
  logic              in_box;
  logic [10:0]       h_ext, v_ext, h_off, v_off;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [1:0]        msg_clamped;
  logic [ADDR_W-1:0] addr_next;

  logic              enable_reg;
  logic [1:0]        msg_reg;
  logic              blink_en_reg;
  rgb_t              colour_reg;
`ifdef TEXT_BG_EN
  rgb_t              bg_reg;
`endif

  logic [ADDR_W-1:0] rom_addr_reg;
  logic              in_box_d1, in_box_d2;
  logic [COL_W-1:0]  col_d1, col_d2;
  logic              texton_reg;
  rgb_t              rgb_reg;

  logic              visible;
  logic              pix_bit;
  logic              text_on;
  rgb_t              text_rgb;

  // 11-bit compares keep the right/bottom edges from wrapping.
  always_comb begin
    h_ext       = {1'b0, bus.HCount};
    v_ext       = {1'b0, bus.VCount};
    frame_start = (bus.HCount == 10'd0) && (bus.VCount == 10'd0);
    in_box      = (h_ext >= X_LO) && (h_ext < X_HI) &&
                  (v_ext >= Y_LO) && (v_ext < Y_HI);
    h_off       = h_ext - X_LO;
    v_off       = v_ext - Y_LO;
    col         = COL_W'(h_off >> SCALE_LOG2);
    row         = ROW_W'(v_off >> SCALE_LOG2);
    msg_clamped = (bus.msg_sel > MSG_MAX) ? MSG_MAX : bus.msg_sel;
    addr_next   = ADDR_W'(int'(msg_reg) * HEIGHT + int'(row));
  end

  // Configuration is only taken at frame start so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg   <= 1'b0;
      msg_reg      <= '0;
      blink_en_reg <= 1'b0;
      colour_reg   <= BLACK;
`ifdef TEXT_BG_EN
      bg_reg       <= BLACK;
`endif
    end else if (frame_start) begin
      enable_reg   <= bus.enable;
      msg_reg      <= msg_clamped;
      blink_en_reg <= bus.blink_en;
      colour_reg   <= bus.colour;
`ifdef TEXT_BG_EN
      bg_reg       <= bus.bgcolour;
`endif
    end
  end

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .blink_en   (blink_en_reg),
    .visible    (visible)
  );

  // Stages 1 and 2: the ROM registers rom_addr, so its word lines up with col_d2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_reg <= '0;
      in_box_d1    <= 1'b0;
      in_box_d2    <= 1'b0;
      col_d1       <= '0;
      col_d2       <= '0;
    end else begin
      if (in_box) begin
        rom_addr_reg <= addr_next;
      end
      in_box_d1 <= in_box;
      col_d1    <= col;
      in_box_d2 <= in_box_d1;
      col_d2    <= col_d1;
    end
  end

  assign pix_bit = bus.rom_data[col_d2];

  always_comb begin
`ifdef TEXT_BG_EN
    text_on  = in_box_d2 & enable_reg & visible;
    text_rgb = pix_bit ? colour_reg : bg_reg;
`else
    text_on  = in_box_d2 & pix_bit & enable_reg & visible;
    text_rgb = colour_reg;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      texton_reg <= 1'b0;
      rgb_reg    <= BLACK;
    end else begin
      texton_reg <= text_on;
      rgb_reg    <= text_on ? text_rgb : BLACK;
    end
  end

  assign bus.rom_addr = rom_addr_reg;
  assign bus.texton   = texton_reg;
  assign bus.rgbtext  = rgb_reg;

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: a default-scale instance with a short
// blink period and a 2x-scaled instance share stimulus and ROM contents.
module tb_text_overlay;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] h_drv = 10'd700;
  logic [9:0] v_drv = 10'd500;
  logic       enable_drv = 1'b1;
  logic [1:0] msg_drv = 2'd0;
  logic       blink_drv = 1'b0;
  logic [2:0] colour_drv = 3'b101;
  logic [2:0] bg_drv = BLUE;

  logic [107:0] rom [128];
  int n_checks = 0;
  int n_fail = 0;

`ifdef TEXT_BG_EN
  localparam bit BG_MODE = 1'b1;
`else
  localparam bit BG_MODE = 1'b0;
`endif
  localparam logic [2:0] CLR_RGB = BG_MODE ? BLUE : BLACK;

  text_overlay_if #(.WIDTH(108), .ADDR_W(7)) ifa ();
  text_overlay_if #(.WIDTH(108), .ADDR_W(7)) ifs ();

  always #5 clk = ~clk;

  assign ifa.HCount = h_drv;     assign ifs.HCount = h_drv;
  assign ifa.VCount = v_drv;     assign ifs.VCount = v_drv;
  assign ifa.enable = enable_drv; assign ifs.enable = enable_drv;
  assign ifa.msg_sel = msg_drv;  assign ifs.msg_sel = msg_drv;
  assign ifa.blink_en = blink_drv; assign ifs.blink_en = blink_drv;
  assign ifa.colour = colour_drv; assign ifs.colour = colour_drv;
`ifdef TEXT_BG_EN
  assign ifa.bgcolour = bg_drv;  assign ifs.bgcolour = bg_drv;
`endif

  always @(posedge clk) begin
    ifa.rom_data <= rom[ifa.rom_addr];
    ifs.rom_data <= rom[ifs.rom_addr];
  end

  text_overlay #(.BLINK_FRAMES(2)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa)
  );

  text_overlay #(.SCALE_LOG2(1)) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (ifs)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic run_pixel(input int hh, input int vv);
    h_drv = 10'(hh);
    v_drv = 10'(vv);
    repeat (TEXT_LATENCY) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    h_drv = 10'd0;
    v_drv = 10'd0;
    @(posedge clk);
    #1;
    h_drv = 10'd700;
    v_drv = 10'd500;
  endtask

  bit blink_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '1;
    rom[1] = 108'h1;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_texton", 32'(ifa.texton), 32'd0);
    check_val("reset_rgb", 32'(ifa.rgbtext), 32'd0);
    check_val("reset_addr", 32'(ifa.rom_addr), 32'd0);
    reset = 1'b0;

    run_pixel(10, 150);
    check_val("dark_before_fs", 32'(ifa.texton), 32'd0);

    frame_start();
    run_pixel(10, 150);
    check_val("a_corner_on", 32'(ifa.texton), 32'd1);
    check_val("a_corner_rgb", 32'(ifa.rgbtext), 32'h5);
    check_val("s_corner_on", 32'(ifs.texton), 32'd1);
    run_pixel(9, 150);
    check_val("a_left_out", 32'(ifa.texton), 32'd0);
    check_val("a_left_rgb", 32'(ifa.rgbtext), 32'd0);
    run_pixel(118, 150);
    check_val("a_right_out", 32'(ifa.texton), 32'd0);
    run_pixel(117, 175);
    check_val("a_last_pix", 32'(ifa.texton), 32'd1);
    check_val("a_last_addr", 32'(ifa.rom_addr), 32'd25);
    run_pixel(10, 176);
    check_val("a_bottom_out", 32'(ifa.texton), 32'd0);
    run_pixel(10, 151);
    check_val("a_col0_lsb", 32'(ifa.texton), 32'd1);
    check_val("s_row0_col0", 32'(ifs.texton), 32'd1);
    run_pixel(11, 151);
    check_val("a_col1_clear", 32'(ifa.texton), 32'(BG_MODE));
    check_val("a_col1_rgb", 32'(ifa.rgbtext), 32'(CLR_RGB));
    check_val("s_scaled_col0", 32'(ifs.texton), 32'd1);
    run_pixel(12, 152);
    check_val("s_row1_col1", 32'(ifs.texton), 32'(BG_MODE));
    check_val("a_row2_col2", 32'(ifa.texton), 32'd1);
    run_pixel(225, 201);
    check_val("s_last_pix", 32'(ifs.texton), 32'd1);
    check_val("a_far_out", 32'(ifa.texton), 32'd0);
    run_pixel(226, 150);
    check_val("s_right_out", 32'(ifs.texton), 32'd0);
    run_pixel(10, 202);
    check_val("s_bottom_out", 32'(ifs.texton), 32'd0);
    check_val("s_bottom_rgb", 32'(ifs.rgbtext), 32'd0);

    msg_drv = 2'd1;
    h_drv = 10'd20; v_drv = 10'd155;
    @(posedge clk); #1;
    check_val("midframe_msg_addr", 32'(ifa.rom_addr), 32'd5);
    frame_start();
    h_drv = 10'd20; v_drv = 10'd155;
    @(posedge clk); #1;
    check_val("msg1_addr", 32'(ifa.rom_addr), 32'd31);
    msg_drv = 2'd2;
    frame_start();
    h_drv = 10'd20; v_drv = 10'd155;
    @(posedge clk); #1;
    check_val("msg2_addr", 32'(ifa.rom_addr), 32'd57);

    msg_drv = 2'd0;
    frame_start();
    run_pixel(10, 150);
    check_val("pre_reset_on", 32'(ifa.texton), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset_texton", 32'(ifa.texton), 32'd0);
    check_val("async_reset_rgb", 32'(ifa.rgbtext), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("dark_after_reset", 32'(ifa.texton), 32'd0);

    for (int f = 0; f < 3; f++) begin
      frame_start();
      run_pixel(10, 150);
      check_val($sformatf("forced_visible_f%0d", f), 32'(ifa.texton), 32'd1);
    end

    blink_drv = 1'b1;
    for (int k = 0; k < 6; k++) begin
      frame_start();
      run_pixel(10, 150);
      check_val($sformatf("blink_frame%0d", k), 32'(ifa.texton), 32'(blink_exp[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
